// File: rtl/gost_magma_core_pkg.sv
// Shared constants and round helpers for the Magma engine: tc26 S-boxes,
// key schedule and the g() mixing function.
package gost_pkg;

    localparam int ROUNDS = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gost_state_e;

    // SBOX[n][x]: pi_n applied to nibble n (pi_0 on bits [3:0]).
    localparam logic [3:0] SBOX [8][16] = '{
        '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
        '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
        '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
        '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
        '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
        '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
        '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
        '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
    };

    // 0-based subkey index; the reversed tail is 7 - (i mod 8) == ~i[2:0].
    function automatic logic [2:0] key_idx(input logic [4:0] rnd, input logic dec);
        logic late;
        late = dec ? (rnd >= 5'd8) : (rnd >= 5'd24);
        return late ? ~rnd[2:0] : rnd[2:0];
    endfunction

    // K1 sits in the top word of the key.
    function automatic logic [31:0] key_word(input logic [255:0] key, input logic [2:0] j);
        return key[{3'(3'd7 - j), 5'd0} +: 32];
    endfunction

    function automatic logic [31:0] gost_g(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] sum;
        logic [31:0] sub;
        sum = a + k;
        for (int n = 0; n < 8; n++) begin
            sub[4*n +: 4] = SBOX[n][sum[4*n +: 4]];
        end
        return {sub[20:0], sub[31:21]};
    endfunction

endpackage

// File: rtl/gost_magma_core_if.sv
// Request/result bundle of gost_magma_core. Counter-mode signals exist only
// when GOST_CTR_EN is defined.
interface gost_magma_core_if;
    import gost_pkg::*;

    // istart is edge-triggered and only honoured while idle; obusy covers the
    // start edge up to (not including) the single-cycle odone, when oblock updates.
    logic          istart;
    logic          ienc_dec;
    logic [255:0]  ikey;
    logic [63:0]   iblock;
    logic [63:0]   oblock;
    logic          odone;
    logic          obusy;
    gost_state_e   ostate;

`ifdef GOST_CTR_EN
    logic          ictr;
    logic [31:0]   iiv;
    logic          iiv_load;

    modport master (
        output istart, ienc_dec, ikey, iblock, ictr, iiv, iiv_load,
        input  oblock, odone, obusy, ostate
    );
    modport slave (
        input  istart, ienc_dec, ikey, iblock, ictr, iiv, iiv_load,
        output oblock, odone, obusy, ostate
    );
`else
    modport master (
        output istart, ienc_dec, ikey, iblock,
        input  oblock, odone, obusy, ostate
    );
    modport slave (
        input  istart, ienc_dec, ikey, iblock,
        output oblock, odone, obusy, ostate
    );
`endif

endinterface

// File: rtl/gost_magma_core_round.sv
// One combinational Magma Feistel step; the final round keeps the halves in
// place instead of swapping.
module gost_round
    import gost_pkg::*;
(
    input  logic [31:0] i_a1,
    input  logic [31:0] i_a0,
    input  logic [31:0] i_key,
    input  logic        i_last,
    output logic [31:0] o_a1,
    output logic [31:0] o_a0
);

    logic [31:0] w_mix;

    assign w_mix = gost_g(i_a0, i_key) ^ i_a1;
    assign o_a1  = i_last ? w_mix : i_a0;
    assign o_a0  = i_last ? i_a0  : w_mix;

endmodule

// File: rtl/gost_magma_core.sv
// Magma block engine evaluating UNROLL rounds per clock (UNROLL in 1,2,4,8).
// Defining GOST_CTR_EN adds a 64-bit counter and keystream (CTR) mode.
module gost_magma_core
    import gost_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic             iclk,
    input  logic             irst,
    gost_magma_core_if.slave bus
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("gost_magma_core: UNROLL must be 1, 2, 4 or 8");
    end

    localparam logic [4:0] STEP      = 5'(UNROLL);
    localparam logic [4:0] LAST_STEP = 5'(ROUNDS - UNROLL);

    gost_state_e   r_state;
    gost_state_e   w_state_nx;
    logic          r_start_d;
    logic [4:0]    r_rnd;
    logic [63:0]   r_a;
    logic [255:0]  r_key;
    logic          r_dec;
    logic [63:0]   r_oblock;
    logic          r_odone;

    logic          w_start_edge;
    logic          w_accept;
    logic          w_finish;
    logic [63:0]   w_a_init;
    logic          w_dec_init;
    logic [63:0]   w_mask;
    logic [63:0]   w_result;
    logic [31:0]   w_a1 [UNROLL+1];
    logic [31:0]   w_a0 [UNROLL+1];

    assign w_start_edge = bus.istart & ~r_start_d;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) r_state <= ST_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_rnd == LAST_STEP) begin
                    w_finish   = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Round chain: stage u handles round r_rnd + u of the current clock.
    assign w_a1[0] = r_a[63:32];
    assign w_a0[0] = r_a[31:0];

    for (genvar u = 0; u < UNROLL; u++) begin : g_stage
        logic [4:0]  w_rnd;
        logic [31:0] w_rk;
        assign w_rnd = r_rnd + 5'(u);
        assign w_rk  = key_word(r_key, key_idx(w_rnd, r_dec));
        gost_round u_round (
            .i_a1   (w_a1[u]),
            .i_a0   (w_a0[u]),
            .i_key  (w_rk),
            .i_last (w_rnd == 5'(ROUNDS - 1)),
            .o_a1   (w_a1[u+1]),
            .o_a0   (w_a0[u+1])
        );
    end

    assign w_result = {w_a1[UNROLL], w_a0[UNROLL]};

`ifdef GOST_CTR_EN
    logic [63:0] r_ctr;
    logic [63:0] r_mask;
    logic        r_ctr_mode;
    logic [63:0] w_ctr_src;

    // A load coinciding with an accepted start feeds the new counter straight in.
    assign w_ctr_src  = bus.iiv_load ? {bus.iiv, 32'h0} : r_ctr;
    assign w_a_init   = bus.ictr ? w_ctr_src : bus.iblock;
    assign w_dec_init = bus.ictr ? 1'b0 : bus.ienc_dec;
    assign w_mask     = r_mask;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_ctr      <= '0;
            r_mask     <= '0;
            r_ctr_mode <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ctr_mode <= bus.ictr;
                r_mask     <= bus.ictr ? bus.iblock : 64'h0;
            end
            if (r_state == ST_IDLE && bus.iiv_load) begin
                r_ctr <= {bus.iiv, 32'h0};
            end else if (w_finish && r_ctr_mode) begin
                r_ctr[31:0] <= r_ctr[31:0] + 32'd1;
            end
        end
    end
`else
    assign w_a_init   = bus.iblock;
    assign w_dec_init = bus.ienc_dec;
    assign w_mask     = 64'h0;
`endif

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_start_d <= 1'b0;
            r_rnd     <= '0;
            r_a       <= '0;
            r_key     <= '0;
            r_dec     <= 1'b0;
            r_oblock  <= '0;
            r_odone   <= 1'b0;
        end else begin
            r_start_d <= bus.istart;
            r_odone   <= w_finish;
            if (w_accept) begin
                r_key <= bus.ikey;
                r_rnd <= '0;
                r_a   <= w_a_init;
                r_dec <= w_dec_init;
            end else if (r_state == ST_RUN) begin
                r_rnd <= r_rnd + STEP;
                r_a   <= w_result;
            end
            if (w_finish) begin
                r_oblock <= w_result ^ w_mask;
            end
        end
    end

    assign bus.oblock = r_oblock;
    assign bus.odone  = r_odone;
    assign bus.obusy  = (r_state == ST_RUN);
    assign bus.ostate = r_state;

endmodule

// File: tb/tb_gost_magma_core.sv
// Bench for gost_magma_core: four engines (UNROLL 1,2,4,8) share one stimulus;
// counter-mode sequences are compiled in when GOST_CTR_EN is defined.
module tb_gost_magma_core;
    import gost_pkg::*;

    localparam int NDUT = 4;
    localparam logic [255:0] KEY  = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [255:0] KEY2 = 256'h00112233445566778899aabbccddeeff0123456789abcdeffedcba9876543210;

    typedef struct packed {
        logic         enc_dec;
        logic [255:0] key;
        logic [63:0]  blk;
        logic [63:0]  exp;
    } vec_t;

    logic          iclk = 1'b0;
    logic          irst = 1'b1;
    logic          istart = 1'b0;
    logic          ienc_dec = 1'b0;
    logic [255:0]  ikey = '0;
    logic [63:0]   iblock = '0;
`ifdef GOST_CTR_EN
    logic          ictr = 1'b0;
    logic [31:0]   iiv = '0;
    logic          iiv_load = 1'b0;
`endif

    logic [63:0]     oblock [NDUT];
    logic [NDUT-1:0] odone;
    logic [NDUT-1:0] obusy;
    gost_state_e     ostate [NDUT];

    always #5 iclk = ~iclk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        gost_magma_core_if u_if ();
        assign u_if.istart   = istart;
        assign u_if.ienc_dec = ienc_dec;
        assign u_if.ikey     = ikey;
        assign u_if.iblock   = iblock;
`ifdef GOST_CTR_EN
        assign u_if.ictr     = ictr;
        assign u_if.iiv      = iiv;
        assign u_if.iiv_load = iiv_load;
`endif
        assign oblock[g] = u_if.oblock;
        assign odone[g]  = u_if.odone;
        assign obusy[g]  = u_if.obusy;
        assign ostate[g] = u_if.ostate;
        gost_magma_core #(.UNROLL(1 << g)) u_dut (
            .iclk (iclk),
            .irst (irst),
            .bus  (u_if)
        );
    end

    // Independent reference: nibble x of pi_n is PI[n][63-4x -: 4].
    localparam logic [63:0] PI [8] = '{
        64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F, 64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
        64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0, 64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
    };

    function automatic logic [63:0] model(input logic [255:0] k, input logic [63:0] b, input logic dec);
        logic [31:0] a1, a0, t, s, rk;
        logic [63:0] row;
        int j;
        a1 = b[63:32];
        a0 = b[31:0];
        for (int i = 0; i < 32; i++) begin
            if (dec) j = (i < 8)  ? i : 7 - (i % 8);
            else     j = (i < 24) ? (i % 8) : 7 - (i % 8);
            rk = k[255 - 32*j -: 32];
            t = a0 + rk;
            for (int n = 0; n < 8; n++) begin
                row = PI[n];
                s[4*n +: 4] = row[63 - 4*t[4*n +: 4] -: 4];
            end
            s = (s << 11) | (s >> 21);
            t = s ^ a1;
            if (i == 31) a1 = t;
            else begin
                a1 = a0;
                a0 = t;
            end
        end
        return {a1, a0};
    endfunction

    int n_checks = 0;
    int n_errors = 0;
    int ec;
    int n_done [NDUT];
    int d1 [NDUT];
    int d2 [NDUT];
    int busy_bad [NDUT];
    bit track_busy = 1'b0;
    vec_t vecs [5];

    function automatic int rlat(input int g);
        return 32 >> g;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        ec = 0;
        for (int g = 0; g < NDUT; g++) begin
            n_done[g]   = 0;
            d1[g]       = -1;
            d2[g]       = -1;
            busy_bad[g] = 0;
        end
    endtask

    // One clock; records odone edges and obusy shape up to the first completion.
    task automatic step();
        @(negedge iclk);
        ec++;
        for (int g = 0; g < NDUT; g++) begin
            if (track_busy && n_done[g] == 0) begin
                if (odone[g] ? obusy[g] : !obusy[g]) busy_bad[g]++;
            end
            if (odone[g]) begin
                n_done[g]++;
                if (n_done[g] == 1)      d1[g] = ec;
                else if (n_done[g] == 2) d2[g] = ec;
            end
        end
    endtask

    task automatic drive_vec(input vec_t v);
        ienc_dec = v.enc_dec;
        ikey     = v.key;
        iblock   = v.blk;
    endtask

    // Called at a negedge with istart low; returns just after edge 0.
    task automatic pulse_start(input vec_t v);
        drive_vec(v);
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
`ifdef GOST_CTR_EN
        iiv_load = 1'b0;
`endif
        clear_rec();
        track_busy = 1'b1;
        for (int g = 0; g < NDUT; g++) if (!obusy[g]) busy_bad[g]++;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        pulse_start(v);
        repeat (34) step();
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s u%0d done_edge", tag, 1 << g), 64'(d1[g]), 64'(rlat(g)));
            check($sformatf("%s u%0d done_count", tag, 1 << g), 64'(n_done[g]), 64'd1);
            check($sformatf("%s u%0d busy_shape", tag, 1 << g), 64'(busy_bad[g]), 64'd0);
            check($sformatf("%s u%0d oblock", tag, 1 << g), oblock[g], v.exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, KEY,  64'hfedcba9876543210, 64'h4ee901e5c2d8ca3d};
        vecs[1] = '{1'b1, KEY,  64'h4ee901e5c2d8ca3d, 64'hfedcba9876543210};
        vecs[2] = '{1'b0, KEY2, 64'h0000000000000000, model(KEY2, 64'h0, 1'b0)};
        vecs[3] = '{1'b1, KEY2, 64'h0123456789abcdef, model(KEY2, 64'h0123456789abcdef, 1'b1)};
        vecs[4] = '{1'b0, KEY,  64'hdeadbeefcafef00d, model(KEY, 64'hdeadbeefcafef00d, 1'b0)};

        check("model_kat_enc", model(KEY, 64'hfedcba9876543210, 1'b0), 64'h4ee901e5c2d8ca3d);

        repeat (3) @(negedge iclk);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("reset u%0d oblock", 1 << g), oblock[g], 64'h0);
            check($sformatf("reset u%0d odone_obusy", 1 << g), {62'h0, odone[g], obusy[g]}, 64'h0);
            check($sformatf("reset u%0d state", 1 << g), 64'(ostate[g]), 64'(ST_IDLE));
        end
        irst = 1'b0;
        repeat (2) @(negedge iclk);

        for (int i = 0; i < 5; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // istart held high for 100 cycles: one operation only.
        drive_vec(vecs[2]);
        istart = 1'b1;
        @(negedge iclk);
        clear_rec();
        track_busy = 1'b1;
        repeat (100) step();
        istart = 1'b0;
        repeat (5) step();
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("hold u%0d done_count", 1 << g), 64'(n_done[g]), 64'd1);
            check($sformatf("hold u%0d done_edge", 1 << g), 64'(d1[g]), 64'(rlat(g)));
            check($sformatf("hold u%0d oblock", 1 << g), oblock[g], vecs[2].exp);
        end

        // Start edges at edge 10 (ignored while running) and edge 33.
        pulse_start(vecs[0]);
        repeat (9) step();
        istart = 1'b1;
        step();
        istart = 1'b0;
        repeat (22) step();
        drive_vec(vecs[1]);
        istart = 1'b1;
        step();
        istart = 1'b0;
        repeat (37) step();
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("restart u%0d done_count", 1 << g), 64'(n_done[g]), (rlat(g) < 10) ? 64'd3 : 64'd2);
            check($sformatf("restart u%0d first_done", 1 << g), 64'(d1[g]), 64'(rlat(g)));
            if (rlat(g) >= 10)
                check($sformatf("restart u%0d second_done", 1 << g), 64'(d2[g]), 64'(33 + rlat(g)));
            check($sformatf("restart u%0d oblock", 1 << g), oblock[g], vecs[1].exp);
        end

        // Asynchronous reset just after edge 10 of a run.
        pulse_start(vecs[4]);
        repeat (9) step();
        @(posedge iclk);
        #1 irst = 1'b1;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("abort u%0d oblock", 1 << g), oblock[g], 64'h0);
            check($sformatf("abort u%0d odone_obusy", 1 << g), {62'h0, odone[g], obusy[g]}, 64'h0);
            check($sformatf("abort u%0d state", 1 << g), 64'(ostate[g]), 64'(ST_IDLE));
        end
        @(negedge iclk);
        irst = 1'b0;
        track_busy = 1'b0;
        clear_rec();
        repeat (40) step();
        for (int g = 0; g < NDUT; g++)
            check($sformatf("abort u%0d no_done", 1 << g), 64'(n_done[g]), 64'd0);
        run_op(vecs[0], "after_abort");

`ifdef GOST_CTR_EN
        begin
            vec_t v;
            logic [63:0] x;
            iiv = 32'h12345678;
            iiv_load = 1'b1;
            ictr = 1'b1;
            v = '{1'b1, KEY, 64'h0, model(KEY, 64'h1234567800000000, 1'b0)};
            run_op(v, "ctr_blk0");
            x = 64'h0f1e2d3c4b5a6978;
            v = '{1'b1, KEY, x, model(KEY, 64'h1234567800000001, 1'b0) ^ x};
            run_op(v, "ctr_blk1");
            force g_dut[0].u_dut.r_ctr = 64'h12345678ffffffff;
            force g_dut[1].u_dut.r_ctr = 64'h12345678ffffffff;
            force g_dut[2].u_dut.r_ctr = 64'h12345678ffffffff;
            force g_dut[3].u_dut.r_ctr = 64'h12345678ffffffff;
            @(negedge iclk);
            release g_dut[0].u_dut.r_ctr;
            release g_dut[1].u_dut.r_ctr;
            release g_dut[2].u_dut.r_ctr;
            release g_dut[3].u_dut.r_ctr;
            v = '{1'b0, KEY, x, model(KEY, 64'h12345678ffffffff, 1'b0) ^ x};
            run_op(v, "ctr_wrap");
            v = '{1'b0, KEY, 64'h0, model(KEY, 64'h1234567800000000, 1'b0)};
            run_op(v, "ctr_after_wrap");
            ictr = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gost_magma_core.md
# gost_magma_core

Parametrised GOST R 34.12-2015 Magma (64-bit block, 256-bit key) engine for the GhostSD data path. It is the successor to the single-round-per-clock GOST wrapper. It keeps the start-edge handshake, adds a busy/done handshake, and adds a compile-time unroll factor that trades area for latency. An optional counter mode produces keystream for sector encryption.

## Interface
- UNROLL, 1: Feistel rounds evaluated per clock. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.
- iclk  in  1  clock; all logic is on the rising edge.
- irst  in  1  reset; asynchronous, active-high.
- istart  in  1  start request; acted on at its rising edge (sampled 1, previous sample 0).
- ienc_dec  in  1  0 = encrypt, 1 = decrypt; sampled at start.
- ikey  in  256  key; K1 = ikey[255:224] … K8 = ikey[31:0]; sampled at start.
- iblock  in  64  input block (a1 = [63:32], a0 = [31:0]); sampled at start.
- oblock  out  64  result; registered, held until the next completion.
- odone  out  1  one-cycle completion pulse.
- obusy  out  1  high from the start edge until the odone cycle, exclusive of the odone cycle.

## Operation
- States: IDLE and RUN.
- Start is accepted only in IDLE. On acceptance: ikey, ienc_dec and iblock are latched, the round counter is cleared, and the state moves to RUN. Inputs may change freely after acceptance.
- A start edge in RUN is ignored and not queued. The edge detector still tracks istart, so a level held high across completion does not restart the engine.
- Round i (0..31): (a1,a0) ← (a0, g(a0,K) ⊕ a1). For i = 31 the swap is omitted.
- g(a,k) = ROL11(S(a + k mod 2^32)). S uses the tc26 Z S-boxes, with π0 applied to nibble [3:0] … π7 to nibble [31:28].
- Key index j (0-based, K = K(j+1)):
  - encrypt: j = i mod 8 for i < 24, otherwise 7 − (i mod 8).
  - decrypt: j = i mod 8 for i < 8, otherwise 7 − (i mod 8).
- Each clock in RUN evaluates UNROLL consecutive rounds and advances the counter by UNROLL. After 32 rounds the result is written to oblock, odone pulses, and the state returns to IDLE.

## Timing
- Reset values: oblock = 0, odone = 0, obusy = 0, state IDLE, edge register 0, counter (CTR) 0.
- Reset mid-operation aborts immediately. No odone is produced for the aborted block.
- The start edge is edge 0. oblock updates and odone rises at edge R = 32/UNROLL:
  - UNROLL = 1: 32 edges.
  - UNROLL = 8: 4 edges.
- obusy rises at edge 0 and falls at edge R.
- Minimum start-to-start spacing is R+1 edges: a new istart rising edge is accepted at edge R+1 at the earliest, since istart must first be sampled low.

## Configuration
- GOST_CTR_EN defined adds three inputs:
  - ictr (1 bit): selects counter mode, sampled at start.
  - iiv (32 bits): counter prefix.
  - iiv_load (1 bit): load pulse.
- Counter behaviour under GOST_CTR_EN:
  - iiv_load in IDLE sets the 64-bit counter to {iiv, 32'h0}. It is ignored in RUN.
  - If iiv_load and an accepted start occur in the same cycle, the load wins and the block uses the newly loaded counter.
  - With ictr = 1, the engine encrypts the counter (ienc_dec is ignored) and produces oblock = E(counter) ⊕ latched iblock.
  - At completion the low 32 bits increment mod 2^32; FFFFFFFF wraps to 0 and the high half is unchanged.
  - With ictr = 0, the engine behaves as plain ECB.
- GOST_CTR_EN undefined: these ports and the counter do not exist, and the block is ECB only.

## Structure
- Package gost_pkg holds:
  - the eight 16×4 S-box constants;
  - ROUNDS = 32;
  - a key-index function (round, enc_dec) → 0..7;
  - the g() function.
- Sub-module gost_round: combinational single Feistel step (a1, a0, round key, last flag). The core instantiates it UNROLL times, chained.

## Test plan
- UNROLL = 1, encrypt: key ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, block fedcba9876543210 → oblock 4ee901e5c2d8ca3d, odone at edge 32, obusy high for edges 0–31.
- UNROLL = 8, decrypt 4ee901e5c2d8ca3d with the same key → fedcba9876543210, odone at edge 4. Repeat for UNROLL = 2 and 4 with the same result.
- istart held high for 100 cycles → exactly one odone. A second rising edge at edge 10 of RUN is ignored. An edge at edge 33 starts a new operation.
- Reset pulsed at edge 10 of RUN → oblock, odone and obusy go to 0 asynchronously, with no odone for the aborted block. A following start completes with the correct vector.
- GOST_CTR_EN, iiv = 12345678, ictr = 1, iblock = 0, two blocks → oblock equals ECB encryption of 1234567800000000, then of 1234567800000001.
- GOST_CTR_EN, counter low half FFFFFFFF → next counter is 1234567800000000, with the high half unchanged.
